rv_muldiv_seq: RTL and testbench

//  Iterative sequencer for the RV32M multiply/divide operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/rv_muldiv_seq_if.sv | 26 ++
 rtl/rv_muldiv_seq.sv | 172 +++++++++++++++++
 tb/tb_rv_muldiv_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv_muldiv_seq_if.sv
// rv_muldiv_seq_if: request/response bundle between the ALU stage
// and the iterative RV32M multiply/divide sequencer.
interface rv_muldiv_seq_if;
   logic        i_flush;
   logic        i_start;
   logic [2:0]  i_funct3;
   logic [31:0] i_op1;
   logic [31:0] i_op2;
   logic [4:0]  i_rd;
   logic        o_busy;
   logic        o_valid;
   logic [31:0] o_result;
   logic [4:0]  o_rd;

   modport master (
      output i_flush, i_start, i_funct3,
      output i_op1, i_op2, i_rd,
      input  o_busy, o_valid, o_result, o_rd
   );

   modport slave (
      input  i_flush, i_start, i_funct3,
      input  i_op1, i_op2, i_rd,
      output o_busy, o_valid, o_result, o_rd
   );
endinterface

// File: rtl/rv_muldiv_seq.sv
// rv_muldiv_seq: iterative RV32M MUL*/DIV*/REM* unit.
// Works on magnitudes and fixes the sign in one FIX cycle.
module rv_muldiv_seq #(
   parameter int BITS_PER_CYCLE = 1,
   parameter bit FAST_SPECIAL   = 1'b1
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   rv_muldiv_seq_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   localparam int NSTEP = 32 / BITS_PER_CYCLE;
   localparam logic [4:0] CNT_INIT = 5'(NSTEP - 1);

   logic [1:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [2:0]  fn_q, fn_d;
   logic [4:0]  rd_q, rd_d;
   logic [63:0] mc_q, mc_d;
   logic [31:0] mr_q, mr_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] rem_q, rem_d;
   logic        pneg_q, pneg_d;
   logic        rneg_q, rneg_d;
   logic [31:0] res_q, res_d;
   logic [4:0]  ord_q, ord_d;

   logic [2:0]  f;
   logic        accept, s1, s2, zdiv, ovf, fast;
   logic [31:0] m1, m2, fast_res;
   logic [63:0] prod;
   logic [31:0] qv, rv, fix_res;
   logic [63:0] mul_step;
   logic [31:0] r_cur, q_step;
   logic [32:0] r_try;

   assign f      = bus.i_funct3;
   assign accept = (state_q == IDLE) & bus.i_start & ~bus.i_flush;
   assign s1     = bus.i_op1[31] & ~(f[0] & (f[1] | f[2]));
   assign s2     = bus.i_op2[31]
                 & ((f == 3'b001) | (f == 3'b100) | (f == 3'b110));
   assign m1     = s1 ? -bus.i_op1 : bus.i_op1;
   assign m2     = s2 ? -bus.i_op2 : bus.i_op2;
   assign zdiv   = (bus.i_op2 == '0);
   assign ovf    = f[2] & ~f[0]
                 & (bus.i_op1 == 32'h8000_0000)
                 & (bus.i_op2 == 32'hFFFF_FFFF);
   assign fast   = FAST_SPECIAL & f[2] & (zdiv | ovf);
   assign fast_res = zdiv ? (f[1] ? bus.i_op1 : 32'hFFFF_FFFF)
                          : (f[1] ? 32'h0 : 32'h8000_0000);

   // One CALC cycle: BITS_PER_CYCLE shift-add or restoring steps.
   always_comb begin
      mul_step = acc_q;
      r_cur    = rem_q;
      q_step   = acc_q[31:0];
      r_try    = '0;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         if (mr_q[k]) mul_step = mul_step + (mc_q << k);
         r_try  = {r_cur, q_step[31]};
         q_step = {q_step[30:0], 1'b0};
         if (r_try >= {1'b0, mr_q}) begin
            r_try     = r_try - {1'b0, mr_q};
            q_step[0] = 1'b1;
         end
         r_cur = r_try[31:0];
      end
   end

   assign prod = pneg_q ? -acc_q : acc_q;
   assign qv   = pneg_q ? -acc_q[31:0] : acc_q[31:0];
   assign rv   = rneg_q ? -rem_q : rem_q;
   assign fix_res = fn_q[2] ? (fn_q[1] ? rv : qv)
                  : ((fn_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32]);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fn_d    = fn_q;
      rd_d    = rd_q;
      mc_d    = mc_q;
      mr_d    = mr_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      pneg_d  = pneg_q;
      rneg_d  = rneg_q;
      res_d   = res_q;
      ord_d   = ord_q;
      if (bus.i_flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (bus.i_start) begin
               fn_d   = f;
               rd_d   = bus.i_rd;
               mc_d   = {32'h0, m1};
               mr_d   = m2;
               acc_d  = f[2] ? {32'h0, m1} : 64'h0;
               rem_d  = '0;
               // x/0 keeps an all-ones quotient even for signed DIV
               pneg_d = (s1 ^ s2) & ~(f[2] & zdiv);
               rneg_d = s1;
               cnt_d  = CNT_INIT;
               if (fast) begin
                  state_d = DONE;
                  res_d   = fast_res;
                  ord_d   = bus.i_rd;
               end else begin
                  state_d = CALC;
               end
            end
            CALC: begin
               if (fn_q[2]) begin
                  acc_d = {32'h0, q_step};
                  rem_d = r_cur;
               end else begin
                  acc_d = mul_step;
                  mc_d  = mc_q << BITS_PER_CYCLE;
                  mr_d  = mr_q >> BITS_PER_CYCLE;
               end
               if (cnt_q == '0) state_d = FIX;
               else cnt_d = cnt_q - 5'd1;
            end
            FIX: begin
               state_d = DONE;
               res_d   = fix_res;
               ord_d   = rd_q;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fn_q    <= '0;
         rd_q    <= '0;
         mc_q    <= '0;
         mr_q    <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         pneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         res_q   <= '0;
         ord_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fn_q    <= fn_d;
         rd_q    <= rd_d;
         mc_q    <= mc_d;
         mr_q    <= mr_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         pneg_q  <= pneg_d;
         rneg_q  <= rneg_d;
         res_q   <= res_d;
         ord_q   <= ord_d;
      end
   end

   assign bus.o_busy   = i_reset_n
                       & (accept | (state_q == CALC) | (state_q == FIX));
   assign bus.o_valid  = (state_q == DONE) & ~bus.i_flush;
   assign bus.o_result = res_q;
   assign bus.o_rd     = ord_q;
endmodule

// File: tb/tb_rv_muldiv_seq.sv
// tb_rv_muldiv_seq: four sequencer variants driven in lockstep,
// each with its own scoreboard fed from an arithmetic model.
module tb_rv_muldiv_seq;
   logic        clk = 1'b0;
   logic        rst_n, st, fl;
   logic [2:0]  f3;
   logic [31:0] a, b;
   logic [4:0]  rd;
   int cyc = 0;
   int total = 0;
   int bad = 0;

   logic        iss_now = 1'b0, act = 1'b0, kill = 1'b0;
   logic [2:0]  iss_f = '0;
   logic [31:0] iss_a = '0, iss_b = '0, iss_res = '0;
   logic [4:0]  iss_rd = '0;
   int iss_c = 0;
   int abort_c = 1 << 30;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          due;
   } exp_t;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int g,
                      input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s[%0d] cyc=%0d got=%h want=%h",
                  nm, g, cyc, got, want);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] f,
                                          input logic [31:0] x, y);
      longint sa, sb, ps;
      longint unsigned ua, ub, pu;
      logic [31:0] r;
      sa = longint'($signed(x));
      sb = longint'($signed(y));
      ua = 64'(x);
      ub = 64'(y);
      r  = '0;
      case (f)
         3'd0: begin ps = sa * sb; r = ps[31:0]; end
         3'd1: begin ps = sa * sb; r = ps[63:32]; end
         3'd2: begin ps = sa * longint'(ub); r = ps[63:32]; end
         3'd3: begin pu = ua * ub; r = pu[63:32]; end
         3'd4: if (y == 0) r = 32'hFFFF_FFFF;
               else begin ps = sa / sb; r = ps[31:0]; end
         3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: if (y == 0) r = x;
               else begin ps = sa % sb; r = ps[31:0]; end
         default: r = (y == 0) ? x : x % y;
      endcase
      return r;
   endfunction

   function automatic int op_lat(input logic [2:0] f,
                                 input logic [31:0] x, y,
                                 input bit fs, input int bpc);
      if (fs && f[2] && (y == 0 || (!f[0] &&
          x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
         return 1;
      return 2 + 32 / bpc;
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   for (genvar g = 0; g < 4; g++) begin : u
      localparam int BPC = (g == 1) ? 2 : (g == 2) ? 4 : 1;
      localparam bit FS  = (g != 3);
      rv_muldiv_seq_if bus();
      assign bus.i_flush  = fl;
      assign bus.i_start  = st;
      assign bus.i_funct3 = f3;
      assign bus.i_op1    = a;
      assign bus.i_op2    = b;
      assign bus.i_rd     = rd;
      rv_muldiv_seq #(.BITS_PER_CYCLE(BPC), .FAST_SPECIAL(FS)) dut (
         .i_clk(clk), .i_reset_n(rst_n), .bus(bus));

      exp_t sbq[$];
      exp_t e;
      logic [31:0] hres;
      logic [4:0]  hrd;
      logic eb;
      int endc;
      initial begin
         hres = '0;
         hrd  = '0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               sbq.delete();
               hres = '0;
               hrd  = '0;
            end
            if (bus.o_valid) begin
               if (sbq.size() == 0) begin
                  chk("spurious_valid", g, 32'd1, 32'd0);
               end else begin
                  e = sbq.pop_front();
                  chk("latency", g, 32'(cyc), 32'(e.due));
                  chk("result", g, bus.o_result, e.res);
                  chk("rd", g, 32'(bus.o_rd), 32'(e.rd));
                  hres = e.res;
                  hrd  = e.rd;
               end
            end else if (sbq.size() != 0 && sbq[0].due == cyc && fl) begin
               // DONE was entered, strobe suppressed by flush
               e = sbq.pop_front();
               hres = e.res;
               hrd  = e.rd;
            end else if (sbq.size() != 0 && sbq[0].due < cyc) begin
               e = sbq.pop_front();
               chk("overdue", g, 32'(cyc), 32'(e.due));
            end
            endc = iss_c + op_lat(iss_f, iss_a, iss_b, FS, BPC) - 1;
            if (abort_c < endc) endc = abort_c;
            eb = rst_n && act && cyc >= iss_c && cyc <= endc;
            chk("busy", g, 32'(bus.o_busy), 32'(eb));
            chk("held_result", g, bus.o_result, hres);
            chk("held_rd", g, 32'(bus.o_rd), 32'(hrd));
            @(posedge clk);
            if (kill) sbq.delete();
            if (iss_now) begin
               e.res = iss_res;
               e.rd  = iss_rd;
               e.due = iss_c + op_lat(iss_f, iss_a, iss_b, FS, BPC);
               sbq.push_back(e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] x, y,
                        input logic [4:0] r, input int hold);
      st = 1'b1; f3 = f; a = x; b = y; rd = r;
      iss_f = f; iss_a = x; iss_b = y; iss_rd = r;
      iss_res = ref_op(f, x, y);
      iss_c = cyc; abort_c = 1 << 30; act = 1'b1; iss_now = 1'b1;
      for (int i = 0; i < hold; i++) begin
         step();
         iss_now = 1'b0;
         a = $urandom; b = $urandom; f3 = 3'($urandom);
      end
      st = 1'b0;
   endtask

   task automatic op(input logic [2:0] f, input logic [31:0] x, y,
                     input logic [4:0] r);
      step();
      issue(f, x, y, r, 1);
      repeat (35) step();
   endtask

   initial begin
      rst_n = 1'b0; st = 1'b0; fl = 1'b0;
      f3 = '0; a = '0; b = '0; rd = '0;
      repeat (3) step();
      rst_n = 1'b1;
      op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3);
      op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4);
      op(3'd2, 32'h8000_0000, 32'h8000_0000, 5'd5);
      op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd6);
      op(3'd5, 32'd5, 32'd0, 5'd7);
      op(3'd7, 32'd5, 32'd0, 5'd8);
      op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9);
      op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10);
      op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
      op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
      op(3'd4, 32'hFFFF_FFFB, 32'd0, 5'd13);
      op(3'd6, 32'hFFFF_FFFB, 32'd0, 5'd14);
      // flush mid-DIV, then restart right after
      step();
      issue(3'd4, 32'd1000, 32'd7, 5'd15, 1);
      repeat (9) step();
      fl = 1'b1; kill = 1'b1; abort_c = cyc;
      step();
      fl = 1'b0; kill = 1'b0;
      issue(3'd4, 32'hFFFF_FC18, 32'd7, 5'd16, 1);
      repeat (35) step();
      // flush wins over start in IDLE
      st = 1'b1; fl = 1'b1; f3 = 3'd0; a = 32'd5; b = 32'd5;
      step();
      st = 1'b0; fl = 1'b0;
      repeat (3) step();
      // start held through DONE of a fast-path op
      issue(3'd5, 32'd9, 32'd0, 5'd17, 2);
      repeat (35) step();
      // async reset mid-operation with start still held
      issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd18, 5);
      st = 1'b1; rst_n = 1'b0; act = 1'b0;
      step();
      rst_n = 1'b1; st = 1'b0;
      repeat (3) step();
      for (int i = 0; i < 60; i++)
         op(3'($urandom), rnd_op(), rnd_op(), 5'($urandom));
      repeat (40) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
